// File: rtl/mc_result_collector.sv
// mc_result_collector: captures per-core MC prices, sums them one core per cycle
// and queues {id, sum} results in a first-word-fall-through FIFO.
module mc_result_collector #(
  parameter int CoreN     = 2,
  parameter int logCoreN  = 1,
  parameter int AccWidth  = 27,
  parameter int PathShift = 10,
  parameter int IdWidth   = 8,
  parameter int FifoDepth = 4,
  parameter int logFifo   = 2
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic [CoreN-1:0]             i_done,
  input  logic [CoreN*AccWidth-1:0]    i_acc,
  input  logic                         i_ready,
  output logic                         o_valid,
  output logic [AccWidth+logCoreN-1:0] o_sum,
  output logic [AccWidth+logCoreN-1:0] o_mean,
  output logic [IdWidth-1:0]           o_id,
  output logic                         o_busy,
  output logic                         o_overrun,
  output logic                         o_full
);
  localparam int SW = AccWidth + logCoreN;
  typedef enum logic [1:0] {IDLE, SUM, PUSH} state_t;
  state_t                r_state;
  logic [AccWidth-1:0]   r_cap [CoreN];
  logic [CoreN-1:0]      r_pend;
  logic [SW-1:0]         r_sum;
  logic [logCoreN-1:0]   r_idx;
  logic [IdWidth-1:0]    r_id;
  logic [IdWidth+SW-1:0] r_mem [FifoDepth];
  logic [logFifo-1:0]    r_wp, r_rp;
  logic [logFifo:0]      r_cnt;
  logic                  r_overrun;
  logic                  w_pop, w_push, w_full;
  logic [IdWidth+SW-1:0] w_head;
  assign w_full = r_cnt == (logFifo+1)'(FifoDepth);
  assign w_pop = o_valid && i_ready;
  // a pop on the same edge frees the slot the pending write needs
  assign w_push = r_state == PUSH && (!w_full || w_pop);
  assign w_head = r_mem[r_rp];
  assign o_valid = r_cnt != '0;
  assign o_sum = o_valid ? w_head[SW-1:0] : '0;
  assign o_id = o_valid ? w_head[SW +: IdWidth] : '0;
  assign o_mean = o_sum >> (logCoreN + PathShift);
  assign o_busy = r_state != IDLE || |r_pend;
  assign o_overrun = r_overrun;
  assign o_full = w_full;
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_pend <= '0;
      r_sum <= '0;
      r_idx <= '0;
      r_id <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_overrun <= 1'b0;
      for (int k = 0; k < CoreN; k++) r_cap[k] <= '0;
    end else begin
      for (int k = 0; k < CoreN; k++)
        if (i_done[k] && (!r_pend[k] || w_push)) r_cap[k] <= i_acc[k*AccWidth +: AccWidth];
      r_pend <= (w_push ? '0 : r_pend) | i_done;
      if (|(i_done & r_pend) && !w_push) r_overrun <= 1'b1;
      case (r_state)
        IDLE: if (&r_pend) begin
          r_sum <= '0;
          r_idx <= '0;
          r_state <= SUM;
        end
        SUM: begin
          r_sum <= r_sum + SW'(r_cap[r_idx]);
          r_idx <= r_idx + 1'b1;
          if (r_idx == logCoreN'(CoreN - 1)) r_state <= PUSH;
        end
        PUSH: if (w_push) begin
          r_id <= r_id + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_push) begin
        r_mem[r_wp] <= {r_id, r_sum};
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (logFifo+1)'(w_push) - (logFifo+1)'(w_pop);
    end
  end
endmodule
